// File: rtl/lif_pkg.sv
// Shared types and helpers for the weighted LIF neuron: FSM state, address width, saturation.
package lif_pkg;

  typedef enum logic [0:0] {INTEG, REFRAC} lif_state_e;

  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  localparam int unsigned LIF_N_IN_DEFAULT   = 4;
  localparam int unsigned LIF_ADDR_W_DEFAULT = addr_width(LIF_N_IN_DEFAULT);

  // Adds at 64 bits, then clamps into the signed range of the given width (width <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        width);
    logic signed [63:0] s;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    s     = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (s > max_v) begin
      s = max_v;
    end else if (s < min_v) begin
      s = min_v;
    end
    return s;
  endfunction

endpackage

// File: rtl/lif_neuron_weighted_if.sv
// Step/config/observation bundle of one weighted LIF neuron.
interface lif_neuron_weighted_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned W_W   = 8,
  parameter int unsigned P_W   = 16,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned AW = lif_pkg::addr_width(N_IN);

  logic                    step_en;
  logic [N_IN-1:0]         in_spk;
  logic signed [P_W-1:0]   thr;
  logic                    w_we;
  logic [AW-1:0]           w_addr;
  logic signed [W_W-1:0]   w_data;
  logic                    spike;
  logic signed [P_W-1:0]   v_mem;
  logic                    refrac;
  logic [CNT_W-1:0]        spike_cnt;

  modport master (
    output step_en, in_spk, thr, w_we, w_addr, w_data,
    input  spike, v_mem, refrac, spike_cnt
  );

  modport slave (
    input  step_en, in_spk, thr, w_we, w_addr, w_data,
    output spike, v_mem, refrac, spike_cnt
  );
endinterface

// File: rtl/lif_weight_sum.sv
// Synaptic weight register file plus masked adder producing a full-width signed sum.
module lif_weight_sum import lif_pkg::*; #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned W_W   = 8,
  parameter int unsigned SUM_W = 17,
  parameter int unsigned AW    = addr_width(N_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    w_we_i,
  input  logic [AW-1:0]           w_addr_i,
  input  logic signed [W_W-1:0]   w_data_i,
  input  logic [N_IN-1:0]         in_spk_i,
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [W_W-1:0] w_q [N_IN];

  // Addresses with no matching index never hit, so out-of-range writes fall away.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= '0;
      end
    end else if (w_we_i) begin
      for (int i = 0; i < N_IN; i++) begin
        if (w_addr_i == AW'(i)) begin
          w_q[i] <= w_data_i;
        end
      end
    end
  end

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_spk_i[i]) begin
        sum_o = sum_o + SUM_W'(w_q[i]);
      end
    end
  end

endmodule

// File: rtl/lif_neuron_weighted.sv
// Weighted leaky integrate-and-fire neuron: leak, saturating integrate, fire, refractory hold.
module lif_neuron_weighted import lif_pkg::*; #(
  parameter int unsigned N_IN         = 4,
  parameter int unsigned W_W          = 8,
  parameter int unsigned P_W          = 16,
  parameter int unsigned LEAK_SHIFT   = 3,
  parameter int unsigned REFRAC_STEPS = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lif_neuron_weighted_if.slave nrn_io
);

  localparam int unsigned SUM_W = P_W + 1;
  localparam int unsigned RC_W  = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  lif_state_e              state_q, state_d;
  logic signed [P_W-1:0]   p_q, p_d;
  logic                    spike_q, spike_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RC_W-1:0]         rcnt_q, rcnt_d;

  logic signed [SUM_W-1:0] sum;
  logic signed [P_W-1:0]   p_leak;
  logic signed [P_W-1:0]   p_new;
  logic                    fire;

  lif_weight_sum #(
    .N_IN  (N_IN),
    .W_W   (W_W),
    .SUM_W (SUM_W)
  ) u_weight_sum (
    .clk_i    (clk),
    .rst_i    (rst),
    .w_we_i   (nrn_io.w_we),
    .w_addr_i (nrn_io.w_addr),
    .w_data_i (nrn_io.w_data),
    .in_spk_i (nrn_io.in_spk),
    .sum_o    (sum)
  );

  // Leak cannot overflow: it moves P toward zero by at most |P|.
  always_comb begin
    p_leak = p_q - (p_q >>> LEAK_SHIFT);
    p_new  = P_W'(sat_add(64'(p_leak), 64'(sum), P_W));
    fire   = (p_new >= nrn_io.thr);
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    if (nrn_io.step_en) begin
      unique case (state_q)
        INTEG: begin
          if (fire) begin
            spike_d = 1'b1;
            p_d     = '0;
            cnt_d   = cnt_q + CNT_W'(1);
            if (REFRAC_STEPS > 0) begin
              rcnt_d  = RC_W'(REFRAC_STEPS);
              state_d = REFRAC;
            end
          end else begin
            p_d = p_new;
          end
        end
        REFRAC: begin
          p_d    = '0;
          rcnt_d = rcnt_q - RC_W'(1);
          if (rcnt_q == RC_W'(1)) begin
            state_d = INTEG;
          end
        end
        default: state_d = INTEG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INTEG;
      p_q     <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign nrn_io.spike     = spike_q;
  assign nrn_io.v_mem     = p_q;
  assign nrn_io.refrac    = (state_q == REFRAC);
  assign nrn_io.spike_cnt = cnt_q;

endmodule

// File: tb/tb_lif_neuron_weighted.sv
// Bench for lif_neuron_weighted: two instances (P_W=16 and P_W=10) against an arithmetic model.
module tb_lif_neuron_weighted;

  localparam int NI = 4;
  localparam int WW = 8;
  localparam int PA = 16;
  localparam int PB = 10;
  localparam int LS = 3;
  localparam int RS = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              step_en = 1'b0;
  logic [3:0]        in_spk  = '0;
  logic              w_we    = 1'b0;
  logic [1:0]        w_addr  = '0;
  logic signed [7:0] w_data  = '0;
  logic signed [15:0] thr_a  = '0;
  logic signed [9:0]  thr_b  = '0;

  lif_neuron_weighted_if #(.N_IN(NI), .W_W(WW), .P_W(PA), .CNT_W(CW)) ifa ();
  lif_neuron_weighted_if #(.N_IN(NI), .W_W(WW), .P_W(PB), .CNT_W(CW)) ifb ();

  assign ifa.step_en = step_en;
  assign ifa.in_spk  = in_spk;
  assign ifa.thr     = thr_a;
  assign ifa.w_we    = w_we;
  assign ifa.w_addr  = w_addr;
  assign ifa.w_data  = w_data;
  assign ifb.step_en = step_en;
  assign ifb.in_spk  = in_spk;
  assign ifb.thr     = thr_b;
  assign ifb.w_we    = w_we;
  assign ifb.w_addr  = w_addr;
  assign ifb.w_data  = w_data;

  lif_neuron_weighted #(
    .N_IN(NI), .W_W(WW), .P_W(PA), .LEAK_SHIFT(LS), .REFRAC_STEPS(RS), .CNT_W(CW)
  ) dut_a (
    .clk    (clk),
    .rst    (rst),
    .nrn_io (ifa)
  );

  lif_neuron_weighted #(
    .N_IN(NI), .W_W(WW), .P_W(PB), .LEAK_SHIFT(LS), .REFRAC_STEPS(RS), .CNT_W(CW)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .nrn_io (ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: potential, remaining refractory steps, spike count, weights, last spike.
  int m_p   [2];
  int m_ref [2];
  int m_cnt [2];
  int m_w   [2][4];
  bit m_spk [2];
  bit m_valid = 1'b0;

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clamp(input int v, input int pw);
    int hi;
    int lo;
    hi = (1 << (pw - 1)) - 1;
    lo = -(1 << (pw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input int dut_v, input int model_v, input int lit);
    chk(name, dut_v, lit);
    chk({name, "_model"}, model_v, lit);
  endtask

  always @(posedge clk) begin
    int pw;
    int th;
    int sum;
    int pn;
    for (int k = 0; k < 2; k++) begin
      pw = (k == 0) ? PA : PB;
      th = (k == 0) ? int'(thr_a) : int'(thr_b);
      if (rst) begin
        m_p[k]   = 0;
        m_ref[k] = 0;
        m_cnt[k] = 0;
        m_spk[k] = 1'b0;
        for (int i = 0; i < 4; i++) m_w[k][i] = 0;
      end else begin
        m_spk[k] = 1'b0;
        if (step_en) begin
          if (m_ref[k] > 0) begin
            m_ref[k] = m_ref[k] - 1;
            m_p[k]   = 0;
          end else begin
            sum = 0;
            for (int i = 0; i < 4; i++) if (in_spk[i]) sum += m_w[k][i];
            pn = clamp(m_p[k] - floor_div(m_p[k], 1 << LS) + sum, pw);
            if (pn >= th) begin
              m_spk[k] = 1'b1;
              m_cnt[k] = (m_cnt[k] + 1) % (1 << CW);
              m_p[k]   = 0;
              m_ref[k] = RS;
            end else begin
              m_p[k] = pn;
            end
          end
        end
        if (w_we) m_w[k][w_addr] = int'(w_data);
      end
    end
    if (rst) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      chk("a_spike",  int'(ifa.spike),     int'(m_spk[0]));
      chk("a_v_mem",  ifa.v_mem,           m_p[0]);
      chk("a_refrac", int'(ifa.refrac),    int'(m_ref[0] > 0));
      chk("a_cnt",    int'(ifa.spike_cnt), m_cnt[0]);
      chk("b_spike",  int'(ifb.spike),     int'(m_spk[1]));
      chk("b_v_mem",  ifb.v_mem,           m_p[1]);
      chk("b_refrac", int'(ifb.refrac),    int'(m_ref[1] > 0));
      chk("b_cnt",    int'(ifb.spike_cnt), m_cnt[1]);
    end
  end

  task automatic wr(input int a, input int d);
    w_we   = 1'b1;
    w_addr = a[1:0];
    w_data = d[7:0];
    @(negedge clk);
    w_we   = 1'b0;
  endtask

  task automatic step(input logic [3:0] s);
    step_en = 1'b1;
    in_spk  = s;
    @(negedge clk);
    step_en = 1'b0;
    in_spk  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pin("rst_v",      ifa.v_mem,            m_p[0],   0);
    pin("rst_cnt",    int'(ifa.spike_cnt),  m_cnt[0], 0);
    pin("rst_refrac", int'(ifa.refrac),     int'(m_ref[0] > 0), 0);

    // Integrate and fire
    for (int i = 0; i < 4; i++) wr(i, 4);
    thr_a = 16'sd10;
    thr_b = 10'sd511;
    step(4'b0001);
    pin("int_s1", ifa.v_mem, m_p[0], 4);
    step(4'b0001);
    pin("int_s2", ifa.v_mem, m_p[0], 8);
    step(4'b0001);
    pin("fire_spike", int'(ifa.spike),     int'(m_spk[0]), 1);
    pin("fire_v",     ifa.v_mem,           m_p[0], 0);
    pin("fire_cnt",   int'(ifa.spike_cnt), m_cnt[0], 1);

    // Refractory
    step(4'b1111);
    pin("ref1_refrac", int'(ifa.refrac), int'(m_ref[0] > 0), 1);
    pin("ref1_spike",  int'(ifa.spike),  int'(m_spk[0]), 0);
    step(4'b1111);
    pin("ref2_refrac", int'(ifa.refrac), int'(m_ref[0] > 0), 0);
    pin("ref2_v",      ifa.v_mem,        m_p[0], 0);
    step(4'b1111);
    pin("post_ref_spike", int'(ifa.spike),     int'(m_spk[0]), 1);
    pin("post_ref_cnt",   int'(ifa.spike_cnt), m_cnt[0], 2);
    step(4'b0000);
    step(4'b0000);

    // Leak
    thr_a = 16'sd32767;
    wr(0, 100);
    step(4'b0001);
    pin("leak_p0", ifa.v_mem, m_p[0], 100);
    step(4'b0000);
    pin("leak_p1", ifa.v_mem, m_p[0], 88);
    step(4'b0000);
    pin("leak_p2", ifa.v_mem, m_p[0], 77);
    step(4'b0000);
    pin("leak_p3", ifa.v_mem, m_p[0], 68);
    do_reset();
    wr(0, -1);
    step(4'b0001);
    pin("neg_p0", ifa.v_mem, m_p[0], -1);
    step(4'b0000);
    pin("neg_leak", ifa.v_mem, m_p[0], 0);

    // Write/step collision uses the old weight
    wr(0, 4);
    w_we = 1'b1; w_addr = 2'd0; w_data = -8'sd8;
    step_en = 1'b1; in_spk = 4'b0001;
    @(negedge clk);
    w_we = 1'b0; step_en = 1'b0; in_spk = '0;
    pin("coll_old", ifa.v_mem, m_p[0], 4);
    step(4'b0001);
    pin("coll_new", ifa.v_mem, m_p[0], -4);

    // Negative threshold fires, then reset lands mid-refractory
    thr_a = -16'sd5;
    step(4'b0000);
    pin("negthr_spike",  int'(ifa.spike),  int'(m_spk[0]), 1);
    pin("negthr_refrac", int'(ifa.refrac), int'(m_ref[0] > 0), 1);
    rst = 1'b1; step_en = 1'b1; in_spk = 4'b1111;
    @(negedge clk);
    rst = 1'b0; step_en = 1'b0; in_spk = '0;
    pin("rst_ref_refrac", int'(ifa.refrac),    int'(m_ref[0] > 0), 0);
    pin("rst_ref_cnt",    int'(ifa.spike_cnt), m_cnt[0], 0);
    thr_a = 16'sd32767;
    step(4'b1111);
    pin("rst_weights", ifa.v_mem, m_p[0], 0);
    wr(0, 3);
    step(4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pin("idle_hold", ifa.v_mem, m_p[0], 3);
    end

    // Saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 127);
    thr_b = 10'sd511;
    step(4'b1111);
    pin("sat_s1", ifb.v_mem, m_p[1], 508);
    step(4'b1111);
    pin("sat_fire", int'(ifb.spike), int'(m_spk[1]), 1);
    step(4'b0000);
    step(4'b0000);
    for (int i = 0; i < 4; i++) wr(i, -128);
    step(4'b1111);
    pin("sat_neg1", ifb.v_mem, m_p[1], -512);
    step(4'b1111);
    pin("sat_neg2", ifb.v_mem, m_p[1], -512);

    // Random traffic, checked every cycle by the model process
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        thr_a = 16'(int'($urandom_range(0, 400)) - 100);
        thr_b = 10'(int'($urandom_range(0, 400)) - 150);
      end
      rst     = ($urandom_range(0, 199) == 0);
      step_en = ($urandom_range(0, 3) != 0);
      in_spk  = 4'($urandom);
      w_we    = ($urandom_range(0, 7) == 0);
      w_addr  = 2'($urandom);
      w_data  = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; step_en = 1'b0; w_we = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
